// File: rtl/instruction_fetch_queued_pkg.sv
// Shared fetch-stage definitions: redirect encodings, NOP word and a bit-width helper.
package instruction_fetch_queued_pkg;

  typedef enum logic [1:0] {
    RDR_NONE = 2'b00,
    RDR_BR   = 2'b01,
    RDR_J    = 2'b10,
    RDR_JR   = 2'b11
  } redirect_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Number of bits needed to hold 'value' (clogb2(2047) = 11).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/instruction_fetch_queued_fetch_queue.sv
// Synchronous FIFO for fetched {pc+4, instruction} pairs; flush empties it in one cycle.
module instruction_fetch_queued_fetch_queue #(
  parameter  int NB_DATA = 64,
  parameter  int DEPTH   = 4,
  localparam int NB_PTR  = $clog2(DEPTH),
  localparam int NB_CNT  = NB_PTR + 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CNT-1:0]  o_count,
  output logic               o_empty
);

  logic [NB_DATA-1:0] r_mem [DEPTH];
  logic [NB_PTR-1:0]  r_rd_ptr;
  logic [NB_PTR-1:0]  r_wr_ptr;
  logic [NB_CNT-1:0]  r_count;
  logic               w_full;
  logic               w_rd;
  logic               w_wr;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == NB_CNT'(DEPTH));
  assign w_rd    = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is allowed then.
  assign w_wr    = i_push & ~i_flush & (~w_full | w_rd);

  always_ff @(posedge i_clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + NB_PTR'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + NB_PTR'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + NB_CNT'(1);
        2'b01:   r_count <= r_count - NB_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_queued.sv
// IF stage: free-running PC generator issuing into a 1-cycle sync RAM, responses buffered in a
// prefetch queue and handed to decode over valid/ready; redirects flush and re-steer the PC.
module instruction_fetch_queued
  import instruction_fetch_queued_pkg::*;
#(
  parameter  int          NB_REG      = 32,
  parameter  int          NB_INSTR    = 32,
  parameter  int          N_ADDR      = 2048,
  parameter  int          NB_INM_I    = 16,
  parameter  int          NB_INM_J    = 26,
  parameter  int          QUEUE_DEPTH = 4,
  parameter  int unsigned RESET_PC    = 0,
  localparam int          NB_ADDR     = clogb2(N_ADDR - 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [1:0]          i_redirect,
  input  logic [NB_REG-1:0]   i_redirect_base,
  input  logic [NB_INM_I-1:0] i_inm_i,
  input  logic [NB_INM_J-1:0] i_inm_j,
  input  logic [NB_REG-1:0]   i_rs,
  output logic [NB_ADDR-1:0]  o_imem_addr,
  output logic                o_imem_en,
  input  logic [NB_INSTR-1:0] i_imem_data,
  output logic [NB_INSTR-1:0] o_ir,
  output logic [NB_REG-1:0]   o_pc,
  output logic                o_ir_valid,
  input  logic                i_ir_ready,
  output logic                o_fetch_fault
);

  localparam int NB_CNT = $clog2(QUEUE_DEPTH) + 1;
  localparam int NB_Q   = NB_REG + NB_INSTR;
  localparam logic [NB_CNT:0] OCC_LIMIT = (NB_CNT + 1)'(QUEUE_DEPTH);

  logic [NB_REG-1:0]  r_pc;
  logic [NB_REG-1:0]  r_tag_pc;
  logic               r_tag_epoch;
  logic               r_epoch;
  logic               r_inflight;
  logic               r_fault;
  logic               r_run;

  logic               w_redirect;
  logic [NB_REG-1:0]  w_target;
  logic [NB_CNT:0]    w_occupancy;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [NB_Q-1:0]    w_q_wdata;
  logic [NB_Q-1:0]    w_q_head;
  logic [NB_CNT-1:0]  w_q_count;
  logic               w_q_empty;

  // Redirects only take effect while the stage is enabled.
  assign w_redirect = i_valid & (i_redirect != 2'b00);

  always_comb begin
    w_target = r_pc;
    case (redirect_e'(i_redirect))
      RDR_BR: w_target = i_redirect_base +
                         ({{(NB_REG - NB_INM_I){i_inm_i[NB_INM_I-1]}}, i_inm_i} << 2);
      RDR_J:  w_target = (i_redirect_base & {4'hF, {(NB_REG - 4){1'b0}}}) |
                         (NB_REG'(i_inm_j) << 2);
      RDR_JR: w_target = i_rs;
      default: w_target = r_pc;
    endcase
  end

  // Queue slots are reserved at issue time so a returning word always has room.
  assign w_occupancy = {1'b0, w_q_count} + {{NB_CNT{1'b0}}, r_inflight};
  assign w_issue     = r_run & i_valid & ~r_fault & ~w_redirect & (w_occupancy < OCC_LIMIT);

  assign w_push    = r_inflight & (r_tag_epoch == r_epoch) & ~w_redirect;
  assign w_pop     = ~w_q_empty & i_ir_ready;
  assign w_q_wdata = {r_tag_pc + NB_REG'(4), i_imem_data};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc        <= NB_REG'(RESET_PC);
      r_tag_pc    <= '0;
      r_tag_epoch <= 1'b0;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_fault     <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_pc    <= r_pc;
        r_tag_epoch <= r_epoch;
      end
      if (w_redirect) begin
        r_pc    <= w_target;
        r_epoch <= ~r_epoch;
        r_fault <= (w_target[1:0] != 2'b00);
      end else if (w_issue) begin
        r_pc <= r_pc + NB_REG'(4);
      end
    end
  end

  instruction_fetch_queued_fetch_queue #(
    .NB_DATA (NB_Q),
    .DEPTH   (QUEUE_DEPTH)
  ) u_fetch_queue (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_q_wdata),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_data  (w_q_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty)
  );

  assign o_imem_addr   = r_pc[NB_ADDR+1:2];
  assign o_imem_en     = w_issue;
  assign o_ir_valid    = ~w_q_empty;
  assign o_ir          = w_q_empty ? NB_INSTR'(NOP) : w_q_head[NB_INSTR-1:0];
  assign o_pc          = w_q_empty ? '0 : w_q_head[NB_Q-1:NB_INSTR];
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_queued.sv
// Randomised and directed bench for the queued fetch stage against a queue-based reference model.
module tb_instruction_fetch_queued;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [1:0]  i_redirect;
  logic [31:0] i_redirect_base;
  logic [15:0] i_inm_i;
  logic [25:0] i_inm_j;
  logic [31:0] i_rs;
  logic [10:0] o_imem_addr;
  logic        o_imem_en;
  logic [31:0] imem_data;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        o_ir_valid;
  logic        i_ir_ready;
  logic        o_fetch_fault;

  logic [31:0] ram [2048];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          m_fault;
  bit          m_hold;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  instruction_fetch_queued dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_valid         (i_valid),
    .i_redirect      (i_redirect),
    .i_redirect_base (i_redirect_base),
    .i_inm_i         (i_inm_i),
    .i_inm_j         (i_inm_j),
    .i_rs            (i_rs),
    .o_imem_addr     (o_imem_addr),
    .o_imem_en       (o_imem_en),
    .i_imem_data     (imem_data),
    .o_ir            (o_ir),
    .o_pc            (o_pc),
    .o_ir_valid      (o_ir_valid),
    .i_ir_ready      (i_ir_ready),
    .o_fetch_fault   (o_fetch_fault)
  );

  always @(posedge clk) begin
    if (o_imem_en) imem_data <= ram[o_imem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_target();
    case (i_redirect)
      2'b01:   return i_redirect_base + 32'($signed(i_inm_i)) * 32'd4;
      2'b10:   return (i_redirect_base & 32'hF000_0000) | (32'(i_inm_j) * 32'd4);
      default: return i_rs;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc      = 32'h0;
    m_infl_pc = 32'h0;
    m_infl    = 1'b0;
    m_fault   = 1'b0;
    m_hold    = 1'b1;
  endtask

  // One clock cycle: compare DUT against the model at the falling edge, then advance the model.
  task automatic step();
    bit          rdr;
    bit          issue;
    int          occ;
    logic [31:0] tgt;
    logic [63:0] head;
    @(negedge clk);
    rdr   = i_valid && (i_redirect != 2'b00);
    occ   = m_q.size() + int'(m_infl);
    issue = !m_hold && i_valid && !m_fault && !rdr && (occ < QD);
    head  = (m_q.size() != 0) ? m_q[0] : 64'h0;
    chk("imem_en", 32'(o_imem_en), 32'(issue));
    if (issue) chk("imem_addr", 32'(o_imem_addr), 32'(m_pc[12:2]));
    chk("ir_valid", 32'(o_ir_valid), 32'(m_q.size() != 0));
    chk("ir", o_ir, head[31:0]);
    chk("pc", o_pc, head[63:32]);
    chk("fault", 32'(o_fetch_fault), 32'(m_fault));
    if (m_q.size() != 0 && i_ir_ready) void'(m_q.pop_front());
    if (rdr) begin
      tgt = m_target();
      m_q.delete();
      m_fault = (tgt[1:0] != 2'b00);
      m_pc    = tgt;
    end else begin
      if (m_infl) m_q.push_back({m_infl_pc + 32'd4, ram[m_infl_pc[12:2]]});
      if (issue) m_pc = m_pc + 32'd4;
    end
    if (issue) m_infl_pc = (rdr ? 32'h0 : m_pc - 32'd4);
    m_infl = issue;
    m_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    for (int k = 0; k < 2048; k++) ram[k] = 32'(k + 1);
    i_reset = 1'b1; i_valid = 1'b1; i_redirect = 2'b00; i_redirect_base = '0;
    i_inm_i = '0; i_inm_j = '0; i_rs = '0; i_ir_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ir_valid", 32'(o_ir_valid), 32'd0);
    chk("rst_ir", o_ir, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_en", 32'(o_imem_en), 32'd0);
    chk("rst_fault", 32'(o_fetch_fault), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // stream from reset
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk("t1_valid", 32'(o_ir_valid), 32'd1);
      chk("t1_ir", o_ir, 32'(k + 1));
      chk("t1_pc", o_pc, 32'(4 * (k + 1)));
      step();
    end

    // backpressure fills the queue
    i_ir_ready = 1'b0;
    repeat (10) step();
    chk("t2_en_low", 32'(o_imem_en), 32'd0);
    chk("t2_head", o_ir, 32'd4);
    i_ir_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (o_ir_valid) begin
        chk("t2_order", o_ir, 32'(4 + got));
        got++;
      end
      step();
    end
    chk("t2_count", 32'(got), 32'd5);

    // branch while full
    i_ir_ready = 1'b0;
    repeat (8) step();
    chk("t3_full", 32'(o_ir_valid), 32'd1);
    i_redirect = 2'b01; i_redirect_base = 32'h10; i_inm_i = 16'hFFFE;
    #1;
    chk("t3_en_redirect", 32'(o_imem_en), 32'd0);
    step();
    i_redirect = 2'b00;
    chk("t3_n1_valid", 32'(o_ir_valid), 32'd0);
    step();
    chk("t3_n2_valid", 32'(o_ir_valid), 32'd0);
    step();
    chk("t3_valid", 32'(o_ir_valid), 32'd1);
    chk("t3_ir", o_ir, 32'd3);
    chk("t3_pc", o_pc, 32'h0000_000C);

    // misaligned jump-reg, then recovery via jump-imm
    i_ir_ready = 1'b1;
    i_redirect = 2'b11; i_rs = 32'h22;
    step();
    i_redirect = 2'b00;
    #1;
    chk("t4_fault", 32'(o_fetch_fault), 32'd1);
    chk("t4_no_issue", 32'(o_imem_en), 32'd0);
    repeat (4) step();
    chk("t4_still_fault", 32'(o_fetch_fault), 32'd1);
    chk("t4_empty", 32'(o_ir_valid), 32'd0);
    i_redirect = 2'b10; i_redirect_base = 32'h0000_0100; i_inm_j = 26'd5;
    step();
    i_redirect = 2'b00;
    chk("t4_fault_clr", 32'(o_fetch_fault), 32'd0);
    repeat (2) step();
    chk("t4_ir", o_ir, 32'd6);
    chk("t4_pc", o_pc, 32'h0000_0018);

    // redirect immediately after an issue
    repeat (3) step();
    #1;
    chk("t5_issue_prev", 32'(o_imem_en), 32'd1);
    step();
    i_redirect = 2'b10; i_redirect_base = 32'h0; i_inm_j = 26'd100;
    step();
    i_redirect = 2'b00;
    chk("t5_n1_valid", 32'(o_ir_valid), 32'd0);
    step();
    chk("t5_n2_valid", 32'(o_ir_valid), 32'd0);
    step();
    chk("t5_ir", o_ir, 32'd101);
    chk("t5_pc", o_pc, 32'h0000_0194);

    // asynchronous reset between edges
    repeat (3) step();
    #2;
    i_reset = 1'b1;
    #1;
    chk("t6_valid", 32'(o_ir_valid), 32'd0);
    chk("t6_ir", o_ir, 32'd0);
    chk("t6_pc", o_pc, 32'd0);
    chk("t6_en", 32'(o_imem_en), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    i_reset = 1'b0;
    repeat (3) step();
    chk("t6_restart_ir", o_ir, 32'd1);
    chk("t6_restart_pc", o_pc, 32'd4);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      i_valid    = ($urandom_range(0, 9) != 0);
      i_ir_ready = ($urandom_range(0, 3) != 0);
      i_redirect = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      i_redirect_base = $urandom & 32'hF000_1FFC;
      i_inm_i    = 16'($urandom);
      i_inm_j    = 26'($urandom);
      i_rs       = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
